// File: rtl/data_path_pkg.sv
// rtl/data_path_pkg.sv - widths and ALU opcodes shared by the single-bus datapath
package data_path_pkg;

  localparam int DATA_W = 32;
  localparam int Z_W    = 64;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_PASS = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/data_path_alu.sv
// rtl/data_path_alu.sv - combinational ALU, A = Y, B = bus, 64-bit result
module alu
  import data_path_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   opcode,
  input  logic              cin,
  input  logic              inc_pc,
  output logic [Z_W-1:0]    result
);

  logic [4:0]              shamt;
  logic [Z_W-1:0]          rot_r;
  logic [Z_W-1:0]          rot_l;
  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic signed [DATA_W-1:0] sra_res;
  logic signed [Z_W-1:0]   prod;

  assign shamt = b[4:0];
  assign sa    = $signed(a);
  assign sb    = $signed(b);
  // Rotates fall out of shifting a doubled copy of A
  assign rot_r   = {a, a} >> shamt;
  assign rot_l   = {a, a} << shamt;
  assign sra_res = sa >>> shamt;
  assign prod    = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});

  always_comb begin
    result = '0;
    if (inc_pc) begin
      result = {{DATA_W{1'b0}}, b + 32'd1};
    end else begin
      case (opcode)
        OP_PASS: result[DATA_W-1:0] = b;
        OP_ADD:  result[DATA_W-1:0] = a + b + {{(DATA_W-1){1'b0}}, cin};
        OP_SUB:  result[DATA_W-1:0] = a - b;
        OP_AND:  result[DATA_W-1:0] = a & b;
        OP_OR:   result[DATA_W-1:0] = a | b;
        OP_ROR:  result[DATA_W-1:0] = rot_r[DATA_W-1:0];
        OP_ROL:  result[DATA_W-1:0] = rot_l[Z_W-1:DATA_W];
        OP_SHR:  result[DATA_W-1:0] = a >> shamt;
        OP_SHRA: result[DATA_W-1:0] = sra_res;
        OP_SHL:  result[DATA_W-1:0] = a << shamt;
        OP_DIV: begin
          // Divide by zero leaves the all-zero default
          if (b != '0) begin
            result[DATA_W-1:0]   = sa / sb;
            result[Z_W-1:DATA_W] = sa % sb;
          end
        end
        OP_MUL:  result = prod;
        OP_NEG:  result[DATA_W-1:0] = -b;
        OP_NOT:  result[DATA_W-1:0] = ~b;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/data_path.sv
// rtl/data_path.sv - single 32-bit bus datapath: GPRs, HI/LO, PC, IR, MAR, MDR, Y, Z
module data_path
  import data_path_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              PCout,
  input  logic              Zhighout,
  input  logic              Zlowout,
  input  logic              MDRout,
  input  logic              R0out,
  input  logic              R2out,
  input  logic              R3out,
  input  logic              R4out,
  input  logic              R5out,
  input  logic              R6out,
  input  logic              R7out,
  input  logic              MARin,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              IRin,
  input  logic              Yin,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              R0in,
  input  logic              R1in,
  input  logic              R2in,
  input  logic              R3in,
  input  logic              R4in,
  input  logic              R5in,
  input  logic              R6in,
  input  logic              R7in,
  input  logic              R8in,
  input  logic              R9in,
  input  logic              R10in,
  input  logic              R11in,
  input  logic              R12in,
  input  logic              R13in,
  input  logic              R14in,
  input  logic              R15in,
  input  logic              ZHighIn,
  input  logic              ZLowIn,
  input  logic              IncPC,
  input  logic              Read,
  input  logic [OP_W-1:0]   opcode,
  input  logic              Cin,
  input  logic [DATA_W-1:0] Mdatain
);

  logic [DATA_W-1:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [DATA_W-1:0] R8, R9, R10, R11, R12, R13, R14, R15;
  logic [DATA_W-1:0] HI, LO, PC, IR, MAR, MDR, Y;
  logic [Z_W-1:0]    Z;

  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] mdr_mux;
  logic [Z_W-1:0]    alu_result;

  // Fixed priority keeps the bus defined if the control unit raises two drivers
  always_comb begin
    bus = '0;
    if      (MDRout)   bus = MDR;
    else if (PCout)    bus = PC;
    else if (Zhighout) bus = Z[Z_W-1:DATA_W];
    else if (Zlowout)  bus = Z[DATA_W-1:0];
    else if (R0out)    bus = R0;
    else if (R2out)    bus = R2;
    else if (R3out)    bus = R3;
    else if (R4out)    bus = R4;
    else if (R5out)    bus = R5;
    else if (R6out)    bus = R6;
    else if (R7out)    bus = R7;
  end

  assign mdr_mux = Read ? Mdatain : bus;

  alu u_alu (
    .a      (Y),
    .b      (bus),
    .opcode (opcode),
    .cin    (Cin),
    .inc_pc (IncPC),
    .result (alu_result)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      R0  <= '0; R1  <= '0; R2  <= '0; R3  <= '0;
      R4  <= '0; R5  <= '0; R6  <= '0; R7  <= '0;
      R8  <= '0; R9  <= '0; R10 <= '0; R11 <= '0;
      R12 <= '0; R13 <= '0; R14 <= '0; R15 <= '0;
    end else begin
      if (R0in)  R0  <= bus;
      if (R1in)  R1  <= bus;
      if (R2in)  R2  <= bus;
      if (R3in)  R3  <= bus;
      if (R4in)  R4  <= bus;
      if (R5in)  R5  <= bus;
      if (R6in)  R6  <= bus;
      if (R7in)  R7  <= bus;
      if (R8in)  R8  <= bus;
      if (R9in)  R9  <= bus;
      if (R10in) R10 <= bus;
      if (R11in) R11 <= bus;
      if (R12in) R12 <= bus;
      if (R13in) R13 <= bus;
      if (R14in) R14 <= bus;
      if (R15in) R15 <= bus;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      HI  <= '0;
      LO  <= '0;
      PC  <= '0;
      IR  <= '0;
      MAR <= '0;
      MDR <= '0;
      Y   <= '0;
      Z   <= '0;
    end else begin
      if (HIin)    HI  <= bus;
      if (LOin)    LO  <= bus;
      if (PCin)    PC  <= bus;
      if (IRin)    IR  <= bus;
      if (MARin)   MAR <= bus;
      if (MDRin)   MDR <= mdr_mux;
      if (Yin)     Y   <= bus;
      // Z halves load independently so a step can capture just the quotient or remainder
      if (ZHighIn) Z[Z_W-1:DATA_W] <= alu_result[Z_W-1:DATA_W];
      if (ZLowIn)  Z[DATA_W-1:0]   <= alu_result[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_data_path.sv
// tb/tb_data_path.sv - directed self-checking bench for data_path
module tb_data_path;

  logic clock, clear;
  logic PCout, Zhighout, Zlowout, MDRout, R0out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic ZHighIn, ZLowIn, IncPC, Read, Cin;
  logic [4:0]  opcode;
  logic [31:0] Mdatain;

  int n_cmp = 0;
  int n_bad = 0;

  data_path dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R0out(R0out), .R2out(R2out), .R3out(R3out), .R4out(R4out),
    .R5out(R5out), .R6out(R6out), .R7out(R7out),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin),
    .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in),
    .R5in(R5in), .R6in(R6in), .R7in(R7in), .R8in(R8in), .R9in(R9in),
    .R10in(R10in), .R11in(R11in), .R12in(R12in), .R13in(R13in),
    .R14in(R14in), .R15in(R15in),
    .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read),
    .opcode(opcode), .Cin(Cin), .Mdatain(Mdatain)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } vec_t;

  vec_t vecs [14] = '{
    '{"pass", 5'b00000, 1'b0, 32'h1,        32'hDEADBEEF, 64'h0000_0000_DEAD_BEEF},
    '{"add",  5'b00011, 1'b1, 32'h14,       32'h12,       64'h0000_0000_0000_0027},
    '{"sub",  5'b00100, 1'b0, 32'h12,       32'h14,       64'h0000_0000_FFFF_FFFE},
    '{"and",  5'b00101, 1'b0, 32'hF0F0,     32'hFF00,     64'h0000_0000_0000_F000},
    '{"or",   5'b00110, 1'b0, 32'hF0F0,     32'hFF00,     64'h0000_0000_0000_FFF0},
    '{"ror",  5'b00111, 1'b0, 32'h1,        32'h4,        64'h0000_0000_1000_0000},
    '{"rol",  5'b01000, 1'b0, 32'h80000001, 32'h1,        64'h0000_0000_0000_0003},
    '{"shr",  5'b01001, 1'b0, 32'h80000000, 32'h4,        64'h0000_0000_0800_0000},
    '{"shra", 5'b01010, 1'b0, 32'h80000000, 32'h4,        64'h0000_0000_F800_0000},
    '{"shl",  5'b01011, 1'b0, 32'h1,        32'h24,       64'h0000_0000_0000_0010},
    '{"sdiv", 5'b01111, 1'b0, 32'hFFFFFFF9, 32'h2,        64'hFFFF_FFFF_FFFF_FFFD},
    '{"neg",  5'b10001, 1'b0, 32'h0,        32'h1,        64'h0000_0000_FFFF_FFFF},
    '{"not",  5'b10010, 1'b0, 32'h0,        32'h0F0F0F0F, 64'h0000_0000_F0F0_F0F0},
    '{"ill",  5'b00001, 1'b0, 32'h5,        32'h5,        64'h0000_0000_0000_0000}
  };

  task automatic idle;
    PCout = 0; Zhighout = 0; Zlowout = 0; MDRout = 0; R0out = 0;
    R2out = 0; R3out = 0; R4out = 0; R5out = 0; R6out = 0; R7out = 0;
    MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; HIin = 0; LOin = 0;
    R0in = 0; R1in = 0; R2in = 0; R3in = 0; R4in = 0; R5in = 0; R6in = 0; R7in = 0;
    R8in = 0; R9in = 0; R10in = 0; R11in = 0; R12in = 0; R13in = 0; R14in = 0; R15in = 0;
    ZHighIn = 0; ZLowIn = 0; IncPC = 0; Read = 0; Cin = 0; opcode = 5'b0;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // dst: 2 -> R2, 6 -> R6, anything else -> LO
  task automatic load_via_mdr(input logic [31:0] v, input int dst);
    idle();
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
    idle();
    MDRout = 1;
    if (dst == 2) R2in = 1;
    else if (dst == 6) R6in = 1;
    else LOin = 1;
    tick();
    idle();
  endtask

  // Y <- R6, then Z <- ALU(Y, R2)
  task automatic alu_step(input logic [4:0] op, input logic c);
    idle();
    R6out = 1; Yin = 1;
    tick();
    idle();
    R2out = 1; opcode = op; Cin = c; ZHighIn = 1; ZLowIn = 1;
    tick();
    idle();
  endtask

  task automatic test_reset;
    clear = 1; idle(); Mdatain = 32'h0;
    #12;
    n_cmp++; if (dut.PC !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0", dut.PC); end
    n_cmp++; if (dut.Z !== 64'h0) begin n_bad++; $display("FAIL reset_z got %h want 0", dut.Z); end
    n_cmp++; if (dut.R15 !== 32'h0) begin n_bad++; $display("FAIL reset_r15 got %h want 0", dut.R15); end
    clear = 0;
    tick();
  endtask

  task automatic test_fetch;
    idle(); Mdatain = 32'h81300000;
    PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1;
    tick();
    idle();
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1;
    tick();
    idle();
    MDRout = 1; IRin = 1;
    tick();
    idle();
    n_cmp++; if (dut.PC !== 32'h1) begin n_bad++; $display("FAIL fetch_pc got %h want 1", dut.PC); end
    n_cmp++; if (dut.MAR !== 32'h0) begin n_bad++; $display("FAIL fetch_mar got %h want 0", dut.MAR); end
    n_cmp++; if (dut.IR !== 32'h81300000) begin n_bad++; $display("FAIL fetch_ir got %h want 81300000", dut.IR); end
  endtask

  task automatic test_load;
    load_via_mdr(32'h12, 2);
    load_via_mdr(32'h14, 6);
    load_via_mdr(32'h18, 0);
    n_cmp++; if (dut.R2 !== 32'h12) begin n_bad++; $display("FAIL load_r2 got %h want 12", dut.R2); end
    n_cmp++; if (dut.R6 !== 32'h14) begin n_bad++; $display("FAIL load_r6 got %h want 14", dut.R6); end
    n_cmp++; if (dut.LO !== 32'h18) begin n_bad++; $display("FAIL load_lo got %h want 18", dut.LO); end
  endtask

  task automatic test_bus_priority;
    idle();
    MDRout = 1; PCout = 1; R2out = 1; R3in = 1;
    tick();
    idle();
    n_cmp++; if (dut.R3 !== 32'h18) begin n_bad++; $display("FAIL prio_mdr got %h want 18", dut.R3); end
    PCout = 1; Zlowout = 1; R2out = 1; R4in = 1;
    tick();
    idle();
    n_cmp++; if (dut.R4 !== 32'h1) begin n_bad++; $display("FAIL prio_pc got %h want 1", dut.R4); end
    R5out = 1; R7out = 1; R1in = 1;
    tick();
    idle();
    n_cmp++; if (dut.R1 !== 32'h0) begin n_bad++; $display("FAIL prio_r5 got %h want 0", dut.R1); end
  endtask

  task automatic mul_t5_t6;
    Zlowout = 1; LOin = 1;
    tick();
    idle();
    Zhighout = 1; HIin = 1;
    tick();
    idle();
  endtask

  task automatic test_mul;
    alu_step(5'b10000, 1'b0);
    n_cmp++; if (dut.Z !== 64'h168) begin n_bad++; $display("FAIL mul_z got %h want 168", dut.Z); end
    mul_t5_t6();
    n_cmp++; if (dut.LO !== 32'h168) begin n_bad++; $display("FAIL mul_lo got %h want 168", dut.LO); end
    n_cmp++; if (dut.HI !== 32'h0) begin n_bad++; $display("FAIL mul_hi got %h want 0", dut.HI); end
    load_via_mdr(32'hFFFFFFFD, 6);
    load_via_mdr(32'h5, 2);
    alu_step(5'b10000, 1'b0);
    mul_t5_t6();
    n_cmp++; if (dut.LO !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL smul_lo got %h want fffffff1", dut.LO); end
    n_cmp++; if (dut.HI !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL smul_hi got %h want ffffffff", dut.HI); end
  endtask

  task automatic test_div;
    load_via_mdr(32'h14, 6);
    load_via_mdr(32'h12, 2);
    alu_step(5'b01111, 1'b0);
    n_cmp++; if (dut.Z !== 64'h0000_0002_0000_0001) begin n_bad++; $display("FAIL div_z got %h want 0000000200000001", dut.Z); end
    load_via_mdr(32'h0, 2);
    alu_step(5'b01111, 1'b0);
    n_cmp++; if (dut.Z !== 64'h0) begin n_bad++; $display("FAIL div0_z got %h want 0", dut.Z); end
  endtask

  task automatic test_alu_ops;
    for (int i = 0; i < 14; i++) begin
      load_via_mdr(vecs[i].a, 6);
      load_via_mdr(vecs[i].b, 2);
      alu_step(vecs[i].op, vecs[i].cin);
      n_cmp++;
      if (dut.Z !== vecs[i].z) begin
        n_bad++;
        $display("FAIL alu_%s got %h want %h", vecs[i].name, dut.Z, vecs[i].z);
      end
    end
  endtask

  task automatic test_incpc_and_self_load;
    load_via_mdr(32'h5, 2);
    idle();
    R2out = 1; IncPC = 1; opcode = 5'b10000; ZHighIn = 1; ZLowIn = 1;
    tick();
    idle();
    n_cmp++; if (dut.Z !== 64'h6) begin n_bad++; $display("FAIL incpc_override got %h want 6", dut.Z); end
    Zlowout = 1; IncPC = 1; ZLowIn = 1;
    tick();
    idle();
    n_cmp++; if (dut.Z !== 64'h7) begin n_bad++; $display("FAIL self_load got %h want 7", dut.Z); end
  endtask

  task automatic test_clear_mid;
    load_via_mdr(32'h12, 2);
    load_via_mdr(32'h14, 6);
    alu_step(5'b10000, 1'b0);
    #2 clear = 1;
    #1;
    n_cmp++; if (dut.Z !== 64'h0) begin n_bad++; $display("FAIL clear_z got %h want 0", dut.Z); end
    n_cmp++; if (dut.R6 !== 32'h0) begin n_bad++; $display("FAIL clear_r6 got %h want 0", dut.R6); end
    n_cmp++; if (dut.HI !== 32'h0) begin n_bad++; $display("FAIL clear_hi got %h want 0", dut.HI); end
    n_cmp++; if (dut.PC !== 32'h0) begin n_bad++; $display("FAIL clear_pc got %h want 0", dut.PC); end
    #1 clear = 0;
    idle();
    Zlowout = 1; LOin = 1;
    tick();
    idle();
    n_cmp++; if (dut.LO !== 32'h0) begin n_bad++; $display("FAIL clear_lo got %h want 0", dut.LO); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_bus_priority();
    test_mul();
    test_div();
    test_alu_ops();
    test_incpc_and_self_load();
    test_clear_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
